// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: state encoding, datapath widths
// and the default access timeout.
package memory_stage_pkg;
  localparam int DATA_W              = 32;
  localparam int REG_IDX_W           = 5;
  localparam int MEM_TIMEOUT_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;
endpackage

// File: rtl/memory_stage_if.sv
// Memory-side request/response bus between the memory stage (master) and
// the data memory or cache (slave).
interface memory_stage_if;
  import memory_stage_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_timeout_counter.sv
// Saturating cycle counter for a pending memory access; tc marks the last
// cycle the access is allowed to stay outstanding.
module mem_timeout_counter #(
  parameter int MAX = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != CNT_W'(MAX))) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // count_q equals the number of WAIT cycles already elapsed
  assign tc = (count_q == CNT_W'(MAX - 1));
endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: branch resolution, a single outstanding data-memory
// access with timeout, and the registered hand-off to write-back.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic                 Branch,
  input  logic                 MemtoReg,
  input  logic                 RegWrite,
  input  logic [DATA_W-1:0]    add_result,
  input  logic [DATA_W-1:0]    ALU_result,
  input  logic [DATA_W-1:0]    read_data_2,
  input  logic                 Zero,
  input  logic [REG_IDX_W-1:0] write_register_index,
  memory_stage_if.master       bus,
  output logic                 PCSrc,
  output logic [DATA_W-1:0]    branch_target,
  output logic                 stall,
  output logic                 mem_error,
  output logic                 wb_valid,
  output logic                 wb_RegWrite,
  output logic                 wb_MemtoReg,
  output logic [DATA_W-1:0]    wb_read_data,
  output logic [DATA_W-1:0]    wb_ALU_result,
  output logic [REG_IDX_W-1:0] wb_write_register_index
);
  state_t state_q;
  state_t state_d;
  logic   is_mem;
  logic   aligned;
  logic   tc;
  logic   issue;
  logic   complete;
  logic   timeout;
  logic   misalign;
  logic   retire_alu;
  logic   fail;
  logic   retire;

  assign PCSrc         = valid_in & Branch & Zero;
  assign branch_target = add_result;

  assign is_mem  = valid_in & (MemRead | MemWrite);
  assign aligned = (ALU_result[1:0] == 2'b00);

  mem_timeout_counter #(
    .MAX (MEM_TIMEOUT)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q == IDLE),
    .enable (state_q == WAIT),
    .tc     (tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    issue      = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    misalign   = 1'b0;
    retire_alu = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && !is_mem) begin
          retire_alu = 1'b1;
        end else if (is_mem && aligned) begin
          issue   = 1'b1;
          stall   = 1'b1;
          state_d = WAIT;
        end else if (is_mem) begin
          misalign = 1'b1;
        end
      end
      WAIT: begin
        // Timeout retires the instruction, so upstream is released the same cycle
        if (bus.mem_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (tc) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fail   = misalign | timeout;
  assign retire = retire_alu | complete | fail;

  // Output registers: memory request and write-back hand-off
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.mem_req             <= 1'b0;
      bus.mem_we              <= 1'b0;
      bus.mem_addr            <= '0;
      bus.mem_wdata           <= '0;
      mem_error               <= 1'b0;
      wb_valid                <= 1'b0;
      wb_RegWrite             <= 1'b0;
      wb_MemtoReg             <= 1'b0;
      wb_read_data            <= '0;
      wb_ALU_result           <= '0;
      wb_write_register_index <= '0;
    end else begin
      wb_valid <= retire;
      if (issue) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= MemWrite;
        bus.mem_addr  <= ALU_result;
        bus.mem_wdata <= read_data_2;
      end else if (complete || timeout) begin
        bus.mem_req <= 1'b0;
      end
      if (fail) begin
        mem_error <= 1'b1;
      end
      if (retire) begin
        wb_RegWrite             <= RegWrite & ~fail;
        wb_MemtoReg             <= MemtoReg;
        wb_ALU_result           <= ALU_result;
        wb_write_register_index <= write_register_index;
      end
      if (complete) begin
        wb_read_data <= bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Directed and randomized bench for memory_stage with a transaction-level
// reference model of retirement, memory-access timing and error stickiness.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int T = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in, MemRead, MemWrite, Branch, MemtoReg, RegWrite, Zero;
  logic [31:0] add_result, ALU_result, read_data_2;
  logic [4:0]  write_register_index;
  logic        PCSrc, stall, mem_error, wb_valid, wb_RegWrite, wb_MemtoReg;
  logic [31:0] branch_target, wb_read_data, wb_ALU_result;
  logic [4:0]  wb_write_register_index;

  int   errors = 0;
  int   checks = 0;
  logic exp_err;

  always #5 clock = ~clock;

  memory_stage_if bus ();

  memory_stage #(.MEM_TIMEOUT(T)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .valid_in                (valid_in),
    .MemRead                 (MemRead),
    .MemWrite                (MemWrite),
    .Branch                  (Branch),
    .MemtoReg                (MemtoReg),
    .RegWrite                (RegWrite),
    .add_result              (add_result),
    .ALU_result              (ALU_result),
    .read_data_2             (read_data_2),
    .Zero                    (Zero),
    .write_register_index    (write_register_index),
    .bus                     (bus),
    .PCSrc                   (PCSrc),
    .branch_target           (branch_target),
    .stall                   (stall),
    .mem_error               (mem_error),
    .wb_valid                (wb_valid),
    .wb_RegWrite             (wb_RegWrite),
    .wb_MemtoReg             (wb_MemtoReg),
    .wb_read_data            (wb_read_data),
    .wb_ALU_result           (wb_ALU_result),
    .wb_write_register_index (wb_write_register_index)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    valid_in             = 1'b0;
    MemRead              = 1'b0;
    MemWrite             = 1'b0;
    Branch               = 1'b0;
    Zero                 = 1'b0;
    MemtoReg             = 1'b0;
    RegWrite             = 1'b0;
    add_result           = $urandom;
    ALU_result           = $urandom;
    read_data_2          = $urandom;
    write_register_index = 5'($urandom);
  endtask

  task automatic idle_check();
    @(negedge clock);
    #1;
    check_bit("idle_wb_valid", wb_valid, 1'b0);
    check_bit("idle_stall", stall, 1'b0);
    check_bit("idle_mem_req", bus.mem_req, 1'b0);
  endtask

  task automatic alu_op(input logic br, input logic zr, input logic rw,
                        input logic [31:0] res, input logic [4:0] rd, input logic [31:0] tgt);
    logic m2r;
    m2r                  = 1'($urandom);
    valid_in             = 1'b1;
    MemRead              = 1'b0;
    MemWrite             = 1'b0;
    Branch               = br;
    Zero                 = zr;
    RegWrite             = rw;
    MemtoReg             = m2r;
    ALU_result           = res;
    add_result           = tgt;
    write_register_index = rd;
    read_data_2          = $urandom;
    #1;
    check_bit("alu_stall", stall, 1'b0);
    check_bit("pcsrc", PCSrc, br & zr);
    check_word("branch_target", branch_target, tgt);
    @(negedge clock);
    clear_inputs();
    #1;
    check_bit("alu_wb_valid", wb_valid, 1'b1);
    check_bit("alu_wb_regwrite", wb_RegWrite, rw);
    check_bit("alu_wb_memtoreg", wb_MemtoReg, m2r);
    check_word("alu_wb_result", wb_ALU_result, res);
    check_word("alu_wb_rd", 32'(wb_write_register_index), 32'(rd));
    check_bit("alu_mem_req", bus.mem_req, 1'b0);
    check_bit("alu_mem_error", mem_error, exp_err);
  endtask

  task automatic mem_op(input logic wr, input logic both, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic rw, input logic [4:0] rd,
                        input int delay, input logic [31:0] rdata);
    logic m2r;
    bit   timed_out;
    int   n_wait;
    int   stall_cycles;
    int   held_cycles;
    int   early_wb;
    timed_out            = (delay >= T);
    n_wait               = timed_out ? T : delay + 1;
    stall_cycles         = 0;
    held_cycles          = 0;
    early_wb             = 0;
    m2r                  = 1'($urandom);
    valid_in             = 1'b1;
    MemWrite             = wr;
    MemRead              = ~wr | both;
    Branch               = 1'b0;
    RegWrite             = rw;
    MemtoReg             = m2r;
    ALU_result           = addr;
    read_data_2          = wdata;
    write_register_index = rd;
    #1;
    check_bit("mem_issue_stall", stall, 1'b1);
    check_bit("mem_issue_no_req_yet", bus.mem_req, 1'b0);
    if (stall) stall_cycles++;
    for (int k = 1; k <= n_wait; k++) begin
      @(negedge clock);
      bus.mem_ready = (!timed_out && k == delay + 1);
      bus.mem_rdata = bus.mem_ready ? rdata : $urandom;
      #1;
      if (bus.mem_req && bus.mem_addr === addr && bus.mem_we === wr && bus.mem_wdata === wdata)
        held_cycles++;
      if (stall) stall_cycles++;
      if (wb_valid) early_wb++;
    end
    @(negedge clock);
    bus.mem_ready = 1'b0;
    clear_inputs();
    #1;
    if (timed_out) exp_err = 1'b1;
    check_word("mem_req_held_cycles", 32'(held_cycles), 32'(n_wait));
    check_word("mem_early_wb_valid", 32'(early_wb), 32'd0);
    if (!timed_out) begin
      check_word("mem_stall_cycles", 32'(stall_cycles), 32'(delay + 1));
      check_word("mem_wb_read_data", wb_read_data, rdata);
    end
    check_bit("mem_wb_valid", wb_valid, 1'b1);
    check_bit("mem_req_dropped", bus.mem_req, 1'b0);
    check_bit("mem_stall_after", stall, 1'b0);
    check_bit("mem_wb_regwrite", wb_RegWrite, timed_out ? 1'b0 : rw);
    check_bit("mem_wb_memtoreg", wb_MemtoReg, m2r);
    check_word("mem_wb_result", wb_ALU_result, addr);
    check_word("mem_wb_rd", 32'(wb_write_register_index), 32'(rd));
    check_bit("mem_error_flag", mem_error, exp_err);
  endtask

  task automatic misaligned_op(input logic wr, input logic [31:0] addr, input logic [4:0] rd);
    valid_in             = 1'b1;
    MemWrite             = wr;
    MemRead              = ~wr;
    RegWrite             = 1'b1;
    MemtoReg             = ~wr;
    ALU_result           = addr;
    write_register_index = rd;
    #1;
    check_bit("mis_stall", stall, 1'b0);
    @(negedge clock);
    clear_inputs();
    #1;
    exp_err = 1'b1;
    check_bit("mis_wb_valid", wb_valid, 1'b1);
    check_bit("mis_wb_regwrite", wb_RegWrite, 1'b0);
    check_bit("mis_mem_error", mem_error, 1'b1);
    check_bit("mis_no_req", bus.mem_req, 1'b0);
    check_word("mis_wb_result", wb_ALU_result, addr);
  endtask

  task automatic reset_mid_wait();
    valid_in      = 1'b1;
    MemRead       = 1'b1;
    MemWrite      = 1'b0;
    RegWrite      = 1'b1;
    ALU_result    = 32'h0000_0040;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_bit("rst_req_before", bus.mem_req, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_bit("rst_async_req", bus.mem_req, 1'b0);
    check_bit("rst_async_wb_valid", wb_valid, 1'b0);
    check_bit("rst_async_error", mem_error, 1'b0);
    exp_err = 1'b0;
    @(negedge clock);
    clear_inputs();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check_bit("rst_no_wb_pulse", wb_valid, 1'b0);
      check_bit("rst_no_req", bus.mem_req, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    reset         = 1'b1;
    exp_err       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    clear_inputs();
    @(negedge clock);
    #1;
    check_bit("rst_mem_req", bus.mem_req, 1'b0);
    check_bit("rst_mem_we", bus.mem_we, 1'b0);
    check_word("rst_mem_addr", bus.mem_addr, 32'h0);
    check_word("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check_bit("rst_wb_valid", wb_valid, 1'b0);
    check_bit("rst_wb_regwrite", wb_RegWrite, 1'b0);
    check_bit("rst_wb_memtoreg", wb_MemtoReg, 1'b0);
    check_word("rst_wb_read_data", wb_read_data, 32'h0);
    check_word("rst_wb_result", wb_ALU_result, 32'h0);
    check_word("rst_wb_rd", 32'(wb_write_register_index), 32'h0);
    check_bit("rst_mem_error", mem_error, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    alu_op(1'b0, 1'b0, 1'b1, 32'h0000_0010, 5'd5, $urandom);
    idle_check();
    alu_op(1'b1, 1'b1, 1'b0, $urandom, 5'd0, 32'h0000_0100);
    alu_op(1'b1, 1'b0, 1'b0, $urandom, 5'd0, 32'h0000_0100);
    idle_check();
    mem_op(1'b0, 1'b0, 32'h0000_0020, $urandom, 1'b1, 5'd7, 3, 32'hDEAD_BEEF);
    idle_check();
    mem_op(1'b1, 1'b0, 32'h0000_0044, 32'h1234_5678, 1'b0, 5'd0, 0, $urandom);
    idle_check();
    mem_op(1'b1, 1'b1, 32'h0000_0048, 32'hCAFE_F00D, 1'b0, 5'd0, 1, $urandom);
    misaligned_op(1'b0, 32'h0000_0022, 5'd9);
    idle_check();
    alu_op(1'b0, 1'b0, 1'b1, 32'h0000_0055, 5'd3, $urandom);
    mem_op(1'b0, 1'b0, 32'h0000_0080, $urandom, 1'b1, 5'd4, T + 5, $urandom);
    idle_check();
    reset_mid_wait();

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      a    = $urandom;
      case (kind)
        0: alu_op(1'($urandom), 1'($urandom), 1'($urandom), a, 5'($urandom), $urandom);
        1: mem_op(1'($urandom), 1'($urandom), {a[31:2], 2'b00}, $urandom, 1'($urandom),
                  5'($urandom), int'($urandom_range(0, T + 2)), $urandom);
        2: misaligned_op(1'($urandom), {a[31:2], 2'($urandom_range(1, 3))}, 5'($urandom));
        default: idle_check();
      endcase
    end
    idle_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
